// File: rtl/vpi_capture_pkg.sv
// Shared types and helpers for the VPI change-capture block.
package vpi_capture_pkg;

  localparam int OVF_WIDTH = 16;

  // Baseline FSM: IDLE has no valid last_value, ARMED compares against it.
  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } capture_state_e;

  // Advance a FIFO pointer; depth is a power of two so masking wraps it.
  function automatic int next_ptr(input int ptr, input int depth);
    return (ptr + 1) & (depth - 1);
  endfunction

endpackage

// File: rtl/vpi_change_capture_if.sv
// Bus between the watched design/consumer side and the change-capture block.
interface vpi_change_capture_if
  import vpi_capture_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int TS_WIDTH = 32
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                 enable;
  logic [WIDTH-1:0]     watch_value;
  logic                 rec_valid;
  logic                 rec_ready;
  logic [TS_WIDTH-1:0]  rec_time;
  logic [WIDTH-1:0]     rec_prev;
  logic [WIDTH-1:0]     rec_value;
  logic [LVL_W-1:0]     level;
  logic [OVF_WIDTH-1:0] overflow_count;

  // Bench/consumer side drives the watched bus and accepts records.
  modport master (
    output enable, watch_value, rec_ready,
    input  rec_valid, rec_time, rec_prev, rec_value, level, overflow_count
  );

  // Capture block side.
  modport slave (
    input  enable, watch_value, rec_ready,
    output rec_valid, rec_time, rec_prev, rec_value, level, overflow_count
  );

endinterface

// File: rtl/vpi_capture_fifo.sv
// First-word-fall-through synchronous FIFO holding packed change records.
module vpi_capture_fifo
  import vpi_capture_pkg::*;
#(
  parameter  int DATA_W = 96,
  parameter  int DEPTH  = 16,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int LVL_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [LVL_W-1:0]  o_level
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [LVL_W-1:0]  r_level;
  logic              w_doPush;
  logic              w_doPop;

  assign o_full   = (r_level == LVL_W'(DEPTH));
  assign o_empty  = (r_level == '0);
  assign o_level  = r_level;
  assign w_doPop  = i_pop && !o_empty;
  // A pop frees the slot the push writes into, so full + pop still accepts.
  assign w_doPush = i_push && (!o_full || w_doPop);
  assign o_data   = o_empty ? '0 : r_mem[r_rptr];

  // Record storage; write-only port, read is combinational for FWFT.
  always_ff @(posedge clk) begin
    if (!rst && w_doPush) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Pointers and occupancy counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_doPush) begin
        r_wptr <= PTR_W'(next_ptr(int'(r_wptr), DEPTH));
      end
      if (w_doPop) begin
        r_rptr <= PTR_W'(next_ptr(int'(r_rptr), DEPTH));
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/vpi_change_capture.sv
// Watches a bus, timestamps every value change and queues records for a consumer.
module vpi_change_capture
  import vpi_capture_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int TS_WIDTH = 32
) (
  input logic                clk,
  input logic                rst,
  vpi_change_capture_if.slave bus
);

  localparam int REC_W = TS_WIDTH + 2 * WIDTH;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  capture_state_e       r_state;
  capture_state_e       w_stateNext;
  logic [TS_WIDTH-1:0]  r_ts;
  logic [WIDTH-1:0]     r_lastValue;
  logic [OVF_WIDTH-1:0] r_ovfCount;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_loadBaseline;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_drop;
  logic [REC_W-1:0]     w_recIn;
  logic [REC_W-1:0]     w_recOut;
  logic [LVL_W-1:0]     w_level;

  assign w_pop   = !w_empty && bus.rec_ready;
  assign w_drop  = w_push && w_full && !w_pop;
  assign w_recIn = {r_ts, r_lastValue, bus.watch_value};

  // Baseline FSM next-state: arm on first enabled cycle, push on change.
  always_comb begin
    w_stateNext    = r_state;
    w_push         = 1'b0;
    w_loadBaseline = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.enable) begin
          w_stateNext    = ARMED;
          w_loadBaseline = 1'b1;
        end
      end
      ARMED: begin
        if (!bus.enable) begin
          w_stateNext = IDLE;
        end else if (bus.watch_value != r_lastValue) begin
          w_push         = 1'b1;
          w_loadBaseline = 1'b1;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_stateNext;
  end

  // Baseline value; still updated on dropped pushes so prev stays truthful.
  always_ff @(posedge clk) begin
    if (rst)                 r_lastValue <= '0;
    else if (w_loadBaseline) r_lastValue <= bus.watch_value;
  end

  // Free-running timestamp, wraps silently.
  always_ff @(posedge clk) begin
    if (rst) r_ts <= '0;
    else     r_ts <= r_ts + 1'b1;
  end

  // Saturating count of records lost to a full FIFO.
  always_ff @(posedge clk) begin
    if (rst)                               r_ovfCount <= '0;
    else if (w_drop && (r_ovfCount != '1)) r_ovfCount <= r_ovfCount + 1'b1;
  end

  vpi_capture_fifo #(
    .DATA_W (REC_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_recIn),
    .o_data  (w_recOut),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign bus.rec_valid      = !w_empty;
  assign bus.rec_time       = w_recOut[REC_W-1 -: TS_WIDTH];
  assign bus.rec_prev       = w_recOut[2*WIDTH-1 -: WIDTH];
  assign bus.rec_value      = w_recOut[WIDTH-1:0];
  assign bus.level          = w_level;
  assign bus.overflow_count = r_ovfCount;

endmodule
